// File: rtl/ssp_pkg.sv
// Shared SSP definitions: FSM state codes, frame constants and counter sizing
// used by both the transmit and receive controllers.
package ssp_pkg;

    localparam int SSP_DATA_W = 8;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOAD      = 2'd1;
    localparam logic [1:0] ST_WAIT_RISE = 2'd2;
    localparam logic [1:0] ST_SHIFT     = 2'd3;

    localparam logic SSP_TXD_IDLE = 1'b0;
    localparam logic SSP_OE_ON    = 1'b0;
    localparam logic SSP_OE_OFF   = 1'b1;
    localparam logic SSP_FSS_ON   = 1'b1;
    localparam logic SSP_FSS_OFF  = 1'b0;

    function automatic int cnt_w(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

endpackage

// File: rtl/ssp_clk_gen.sv
// Free-running serial clock divider; toggles every HALF_PER cycles, no backpressure.
// rise is a one-cycle strobe in the cycle whose closing edge takes sclk 0->1.
module ssp_clk_gen #(
    parameter int HALF_PER = 1
) (
    input  logic clk,
    input  logic rst,
    output logic sclk,
    output logic rise
);

    localparam int                DIV_W   = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
    localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(HALF_PER - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             sclk_q, sclk_d;
    logic             wrap;

    always_comb begin
        wrap   = (div_q == DIV_MAX);
        div_d  = wrap ? '0 : div_q + DIV_W'(1);
        sclk_d = wrap ? ~sclk_q : sclk_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;
    assign rise = wrap & ~sclk_q;

endmodule

// File: rtl/ssp_tx_ctrl.sv
// SSP transmit controller: pops the TX FIFO and shifts bytes out MSB first behind a frame pulse.
// Pop one cycle after EMPTY=0 in IDLE; streams back-to-back while the FIFO stays non-empty.
module ssp_tx_ctrl
    import ssp_pkg::*;
#(
    parameter int DATA_W   = SSP_DATA_W,
    parameter int HALF_PER = 1
) (
    input  logic              PCLK,
    input  logic              CLEAR,
    input  logic [DATA_W-1:0] TxDATA,
    input  logic              EMPTY,
    output logic              LOGICWRITE,
    output logic              SSPCLKOUT,
    output logic              SSPFSSOUT,
    output logic              SSPTXD,
    output logic              SSPOE_B
);

    localparam int               CNT_W   = cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DATA_W - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              last_q, last_d;
    logic              lw_q, lw_d;
    logic              fss_q, fss_d;
    logic              txd_q, txd_d;
    logic              oe_b_q, oe_b_d;
    logic              clk_rise;

    ssp_clk_gen #(.HALF_PER(HALF_PER)) u_clk_gen (
        .clk  (PCLK),
        .rst  (CLEAR),
        .sclk (SSPCLKOUT),
        .rise (clk_rise)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        last_d  = last_q;
        lw_d    = 1'b0;
        fss_d   = fss_q;
        txd_d   = txd_q;
        oe_b_d  = oe_b_q;

        case (state_q)
            ST_IDLE: begin
                if (!EMPTY) begin
                    lw_d    = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_WAIT_RISE;
            ST_WAIT_RISE: begin
                if (clk_rise) begin
                    fss_d   = SSP_FSS_ON;
                    oe_b_d  = SSP_OE_ON;
                    txd_d   = SSP_TXD_IDLE;
                    cnt_d   = CNT_TOP;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (clk_rise) begin
                    fss_d = SSP_FSS_OFF;
                    if (last_q) begin
                        oe_b_d  = SSP_OE_OFF;
                        txd_d   = SSP_TXD_IDLE;
                        last_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        txd_d   = shift_q[DATA_W-1];
                        shift_d = shift_q << 1;
                        cnt_d   = cnt_q - CNT_W'(1);
                        // LSB decision: chain the next byte, its frame pulse overlapping this LSB
                        if (cnt_q == '0) begin
                            if (!EMPTY) begin
                                lw_d  = 1'b1;
                                fss_d = SSP_FSS_ON;
                                cnt_d = CNT_TOP;
                            end else begin
                                last_d = 1'b1;
                                cnt_d  = '0;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Head byte is captured on the edge that retires the pop; never coincides with a rise.
        if (lw_q) begin
            shift_d = TxDATA;
        end
    end

    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            last_q  <= 1'b0;
            lw_q    <= 1'b0;
            fss_q   <= SSP_FSS_OFF;
            txd_q   <= SSP_TXD_IDLE;
            oe_b_q  <= SSP_OE_OFF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            lw_q    <= lw_d;
            fss_q   <= fss_d;
            txd_q   <= txd_d;
            oe_b_q  <= oe_b_d;
        end
    end

    assign LOGICWRITE = lw_q;
    assign SSPFSSOUT  = fss_q;
    assign SSPTXD     = txd_q;
    assign SSPOE_B    = oe_b_q;

endmodule

// File: tb/tb_ssp_tx_ctrl.sv
// Bench for ssp_tx_ctrl: two instances (HALF_PER 1 and 3), FIFO model, pin-level scoreboard.
module tb_ssp_tx_ctrl;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic       clr    [2] = '{1'b1, 1'b1};
    logic       empty  [2] = '{1'b1, 1'b1};
    logic [7:0] txdata [2] = '{8'h00, 8'h00};
    wire  [1:0] lw, sclk, fss, txd, oeb;

    ssp_tx_ctrl #(.DATA_W(8), .HALF_PER(1)) u_dut0 (
        .PCLK(pclk), .CLEAR(clr[0]), .TxDATA(txdata[0]), .EMPTY(empty[0]),
        .LOGICWRITE(lw[0]), .SSPCLKOUT(sclk[0]), .SSPFSSOUT(fss[0]),
        .SSPTXD(txd[0]), .SSPOE_B(oeb[0])
    );

    ssp_tx_ctrl #(.DATA_W(8), .HALF_PER(3)) u_dut1 (
        .PCLK(pclk), .CLEAR(clr[1]), .TxDATA(txdata[1]), .EMPTY(empty[1]),
        .LOGICWRITE(lw[1]), .SSPCLKOUT(sclk[1]), .SSPFSSOUT(fss[1]),
        .SSPTXD(txd[1]), .SSPOE_B(oeb[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // FIFO contents and expected pin stream per instance; entry = {oe_b, fss, txd} per SCLK period
    logic [7:0] fmem [2][16];
    int         fhead [2] = '{0, 0};
    int         ftail [2] = '{0, 0};
    logic [2:0] emem [2][1024];
    int         ewr [2] = '{0, 0};
    int         erd [2] = '{0, 0};

    int         lw_cnt [2] = '{0, 0};
    int         act_cnt [2] = '{0, 0};
    logic       lw_s [2] = '{1'b0, 1'b0};
    logic       prev_sclk [2], prev_act [2], lw_prev [2], emp_prev [2];
    logic       wait_lw [2], wait_fss [2], first_run [2];
    logic [2:0] prev_smp [2];
    int         run [2], t_emp [2], t_lw [2], last_rise [2];
    logic [2:0] smp;
    logic       rs;

    function automatic int hp(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIFO model: pops on each cycle the DUT held LOGICWRITE high
    always @(posedge pclk) begin
        #1;
        for (int g = 0; g < 2; g++) begin
            if (lw_s[g] && ftail[g] != fhead[g]) fhead[g]++;
            empty[g]  = (ftail[g] == fhead[g]);
            txdata[g] = (ftail[g] != fhead[g]) ? fmem[g][fhead[g] % 16] : 8'h00;
        end
    end

    // Monitor: protocol rules every cycle, scoreboard pop on every SCLK rise with an active frame
    always @(negedge pclk) begin
        cyc++;
        for (int g = 0; g < 2; g++) begin
            smp = {oeb[g], fss[g], txd[g]};
            if (clr[g]) begin
                prev_smp[g]  = smp;
                prev_sclk[g] = sclk[g];
                run[g]       = 0;
                first_run[g] = 1'b1;
                prev_act[g]  = 1'b0;
                lw_prev[g]   = 1'b0;
                lw_s[g]      = 1'b0;
                emp_prev[g]  = empty[g];
                wait_lw[g]   = 1'b0;
                wait_fss[g]  = 1'b0;
                last_rise[g] = -1;
            end else begin
                lw_s[g] = lw[g];
                if (lw[g]) begin
                    lw_cnt[g]++;
                    chk(!empty[g], "pop_while_empty", int'(empty[g]), 0);
                    chk(!lw_prev[g], "pop_back_to_back", int'(lw_prev[g]), 0);
                end
                if (emp_prev[g] && !empty[g]) begin
                    wait_lw[g] = 1'b1;
                    t_emp[g]   = cyc;
                end else if (wait_lw[g] && (lw[g] || cyc - t_emp[g] > 1)) begin
                    chk(lw[g] && (cyc - t_emp[g] == 1), "pop_latency", cyc - t_emp[g], 1);
                    wait_lw[g] = 1'b0;
                    if (lw[g]) begin
                        wait_fss[g] = 1'b1;
                        t_lw[g]     = cyc;
                    end
                end
                if (wait_fss[g] && (fss[g] || cyc - t_lw[g] > 2 * hp(g) + 1)) begin
                    chk(fss[g] && (cyc - t_lw[g] >= 2) && (cyc - t_lw[g] <= 2 * hp(g) + 1),
                        "fss_latency", cyc - t_lw[g], 2 * hp(g) + 1);
                    wait_fss[g] = 1'b0;
                end

                rs = !prev_sclk[g] && sclk[g];
                if (sclk[g] != prev_sclk[g]) begin
                    if (!first_run[g]) chk(run[g] == hp(g), "sclk_half_period", run[g], hp(g));
                    first_run[g] = 1'b0;
                    run[g]       = 1;
                end else begin
                    run[g]++;
                end
                if (smp != prev_smp[g]) chk(rs, "pin_change_off_rise", int'(smp), int'(prev_smp[g]));

                if (rs) begin
                    if (last_rise[g] >= 0)
                        chk(cyc - last_rise[g] == 2 * hp(g), "bit_period", cyc - last_rise[g], 2 * hp(g));
                    last_rise[g] = cyc;
                    if (!smp[2] || prev_act[g]) begin
                        chk(erd[g] != ewr[g], "unexpected_output", int'(smp), 0);
                        if (erd[g] != ewr[g]) begin
                            chk(smp == emem[g][erd[g] % 1024], "serial_out",
                                int'(smp), int'(emem[g][erd[g] % 1024]));
                            erd[g]++;
                            act_cnt[g]++;
                        end
                    end
                    prev_act[g] = !smp[2];
                end
                prev_sclk[g] = sclk[g];
                prev_smp[g]  = smp;
                lw_prev[g]   = lw[g];
                emp_prev[g]  = empty[g];
            end
        end
    end

    // Reference: frame pulse period, MSB-first bits (frame pulse on each non-final LSB), idle period
    task automatic push_burst(input int g, input int n, input logic [7:0] b [4]);
        logic [7:0] v;
        emem[g][ewr[g] % 1024] = 3'b010;
        ewr[g]++;
        for (int i = 0; i < n; i++) begin
            v = b[i];
            fmem[g][ftail[g] % 16] = v;
            ftail[g]++;
            for (int k = 7; k >= 0; k--) begin
                emem[g][ewr[g] % 1024] = {1'b0, (k == 0) && (i != n - 1), v[k]};
                ewr[g]++;
            end
        end
        emem[g][ewr[g] % 1024] = 3'b100;
        ewr[g]++;
    endtask

    task automatic wait_idle(input int g);
        int t = 0;
        while ((erd[g] != ewr[g] || ftail[g] != fhead[g]) && t < 3000) begin
            @(negedge pclk);
            t++;
        end
        chk(t < 3000, "idle_timeout", t, 3000);
        repeat (3) @(negedge pclk);
    endtask

    task automatic send(input int g, input int n, input logic [7:0] b [4]);
        int pre = lw_cnt[g];
        push_burst(g, n, b);
        wait_idle(g);
        chk(lw_cnt[g] - pre == n, "pop_count", lw_cnt[g] - pre, n);
        chk(ftail[g] == fhead[g], "fifo_drained", ftail[g] - fhead[g], 0);
    endtask

    task automatic check_reset(input int g);
        chk(lw[g] == 1'b0, "rst_logicwrite", int'(lw[g]), 0);
        chk(sclk[g] == 1'b0, "rst_sclk", int'(sclk[g]), 0);
        chk(fss[g] == 1'b0, "rst_fss", int'(fss[g]), 0);
        chk(txd[g] == 1'b0, "rst_txd", int'(txd[g]), 0);
        chk(oeb[g] == 1'b1, "rst_oe_b", int'(oeb[g]), 1);
    endtask

    initial begin
        logic [7:0] b [4];
        int pre, a0, t, n;

        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check_reset(0);
        check_reset(1);
        @(posedge pclk);
        #1;
        clr[0] = 1'b0;
        clr[1] = 1'b0;

        repeat (50) @(posedge pclk);
        @(negedge pclk);
        chk(lw_cnt[0] == 0, "idle_no_pop", lw_cnt[0], 0);
        chk(oeb[0] == 1'b1, "idle_oe_b", int'(oeb[0]), 1);
        chk(txd[0] == 1'b0, "idle_txd", int'(txd[0]), 0);

        b = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send(0, 1, b);

        b = '{8'h3C, 8'hFF, 8'h01, 8'h00};
        send(0, 3, b);

        // Abort mid-frame: 0x81 cut during bit 4 (frame pulse + bits 7..4 seen)
        pre = lw_cnt[0];
        a0  = act_cnt[0];
        b   = '{8'h81, 8'h00, 8'h00, 8'h00};
        push_burst(0, 1, b);
        t = 0;
        while (act_cnt[0] < a0 + 5 && t < 500) begin
            @(negedge pclk);
            t++;
        end
        chk(t < 500, "clear_setup_timeout", t, 500);
        @(posedge pclk);
        #1;
        clr[0] = 1'b1;
        ewr[0] = erd[0];
        @(posedge pclk);
        @(negedge pclk);
        check_reset(0);
        repeat (2) @(posedge pclk);
        #1;
        clr[0] = 1'b0;
        repeat (20) @(negedge pclk);
        chk(lw_cnt[0] == pre + 1, "pops_after_clear", lw_cnt[0] - pre, 1);
        chk(oeb[0] == 1'b1, "clear_idle_oe_b", int'(oeb[0]), 1);
        chk(txd[0] == 1'b0, "clear_idle_txd", int'(txd[0]), 0);

        b = '{8'h5A, 8'h00, 8'h00, 8'h00};
        send(1, 1, b);

        for (int it = 0; it < 8; it++) begin
            for (int g = 0; g < 2; g++) begin
                n = $urandom_range(1, 4);
                for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
                send(g, n, b);
            end
        end

        for (int g = 0; g < 2; g++) chk(erd[g] == ewr[g], "scoreboard_empty", ewr[g] - erd[g], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
